// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles SYNC/ADDR/DATA/CHK byte frames into register-write strobes, counting bad frames.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_parser #(
   parameter logic [7:0]        SYNC_BYTE   = 8'hA5,
   parameter int                TO_WID      = 16,
   parameter logic [TO_WID-1:0] TIMEOUT_CYC = 16'd52100
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_dataen,
   output logic       o_wr_en,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_err,
   output logic [7:0] o_err_cnt,
   output logic       o_busy
);
   typedef enum logic [1:0] {IDLE, S_ADDR, S_DATA, S_CHK} state_t;
   state_t     state;
   logic [7:0] addr_r, data_r, sum;
   logic [7:0] cnt_inc;
   assign sum     = addr_r + data_r;
   assign cnt_inc = (o_err_cnt == 8'hFF) ? 8'hFF : o_err_cnt + 8'd1;
   assign o_busy  = state != IDLE;
`ifdef CMD_TIMEOUT_EN
   logic [TO_WID-1:0] to_cnt;
   logic              expire;
   assign expire = (state != IDLE) && !i_dataen && (to_cnt == TIMEOUT_CYC - 1'b1);
   always_ff @(posedge i_clk)
      if (i_rst) to_cnt <= '0;
      else       to_cnt <= (i_dataen || state == IDLE) ? '0 : to_cnt + 1'b1;
`else
   logic expire;
   assign expire = 1'b0;
`endif
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         addr_r    <= '0;
         data_r    <= '0;
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
         o_err     <= 1'b0;
         o_err_cnt <= '0;
      end else begin
         o_wr_en <= 1'b0;
         o_err   <= 1'b0;
         if (expire) begin
            state     <= IDLE;
            o_err     <= 1'b1;
            o_err_cnt <= cnt_inc;
         end else if (i_dataen) begin
            case (state)
               IDLE:   state <= (i_data == SYNC_BYTE) ? S_ADDR : IDLE;
               S_ADDR: begin addr_r <= i_data; state <= S_DATA; end
               S_DATA: begin data_r <= i_data; state <= S_CHK; end
               default: begin
                  state <= IDLE;
                  if (i_data == sum) begin
                     o_wr_en   <= 1'b1;
                     o_wr_addr <= addr_r;
                     o_wr_data <= data_r;
                  end else begin
                     o_err     <= 1'b1;
                     o_err_cnt <= cnt_inc;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: scoreboard bench for uart_cmd_parser; a byte-level frame model
// pushes expected write/error events that a monitor pops as the DUT produces them.
module tb_uart_cmd_parser;
   localparam logic [15:0] TO = 16'd200;
   logic       clk = 1'b0, rst = 1'b1, dataen = 1'b0;
   logic [7:0] data = '0;
   logic       wr_en, err, busy;
   logic [7:0] wr_addr, wr_data, err_cnt;
   int checks = 0, errors = 0;

   uart_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_dataen(dataen),
      .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_err(err), .o_err_cnt(err_cnt), .o_busy(busy));

   always #5 clk = ~clk;

   typedef struct {logic e; logic [7:0] a; logic [7:0] d; logic [7:0] c;} ev_t;
   ev_t q[$];
   int m_st = 0;
   logic [7:0] m_a = '0, m_d = '0, m_wa = '0, m_wd = '0, m_cnt = '0;

   always @(negedge clk) if (!rst) begin
      if (wr_en && err) begin
         checks++; errors++;
         $display("FAIL excl: wr_en and err both high");
      end
      if (wr_en || err) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: wr_en=%b err=%b with nothing expected", wr_en, err);
         end else begin
            ev_t x;
            x = q.pop_front();
            if (err !== x.e || wr_addr !== x.a || wr_data !== x.d || err_cnt !== x.c) begin
               errors++;
               $display("FAIL event: got err=%b addr=%h data=%h cnt=%h, want err=%b addr=%h data=%h cnt=%h",
                        err, wr_addr, wr_data, err_cnt, x.e, x.a, x.d, x.c);
            end
         end
      end
   end

   task automatic push_ev(input logic e);
      if (e) m_cnt = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      q.push_back('{e, m_wa, m_wd, m_cnt});
   endtask

   task automatic model_reset();
      m_st = 0; m_wa = '0; m_wd = '0; m_cnt = '0;
      q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      case (m_st)
         0: if (b == 8'hA5) m_st = 1;
         1: begin m_a = b; m_st = 2; end
         2: begin m_d = b; m_st = 3; end
         default: begin
            if (b == 8'(m_a + m_d)) begin m_wa = m_a; m_wd = m_d; push_ev(1'b0); end
            else push_ev(1'b1);
            m_st = 0;
         end
      endcase
      @(negedge clk); data = b; dataen = 1'b1;
      @(negedge clk); dataen = 1'b0;
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL latency: %0d events still pending one cycle after byte %h", q.size(), b);
         q.delete();
      end
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
      send_byte(8'hA5); send_byte(a); send_byte(d); send_byte(c);
   endtask

   task automatic check_regs(input string nm, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] c, input logic b);
      checks++;
      if (wr_addr !== a || wr_data !== d || err_cnt !== c || busy !== b) begin
         errors++;
         $display("FAIL %s: got addr=%h data=%h cnt=%h busy=%b, want addr=%h data=%h cnt=%h busy=%b",
                  nm, wr_addr, wr_data, err_cnt, busy, a, d, c, b);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_reset();
      checks++;
      if (wr_en !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: got wr_en=%b err=%b, want 0 0", wr_en, err);
      end
      check_regs("reset_regs", 8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      do_reset();
   endtask

   task automatic test_good();
      send_frame(8'h10, 8'h22, 8'h32);
      check_regs("good", 8'h10, 8'h22, 8'h00, 1'b0);
   endtask

   task automatic test_bad();
      send_frame(8'h10, 8'h22, 8'h33);
      check_regs("bad", 8'h10, 8'h22, 8'h01, 1'b0);
   endtask

   task automatic test_junk_carry();
      send_byte(8'h00); send_byte(8'hFF);
      check_regs("junk_idle", 8'h10, 8'h22, 8'h01, 1'b0);
      send_byte(8'hA5);
      check_regs("busy_after_sync", 8'h10, 8'h22, 8'h01, 1'b1);
      send_byte(8'hF0); send_byte(8'h20); send_byte(8'h10);
      check_regs("carry", 8'hF0, 8'h20, 8'h01, 1'b0);
   endtask

   task automatic test_sync_as_addr();
      send_frame(8'hA5, 8'h01, 8'hA6);
      check_regs("sync_addr", 8'hA5, 8'h01, 8'h01, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         logic [7:0] a, d, c;
         a = 8'($urandom); d = 8'($urandom);
         c = ($urandom_range(0, 1) == 0) ? 8'(a + d) : 8'(a + d + 8'($urandom_range(1, 255)));
         send_frame(a, d, c);
      end
      check_regs("random", m_wa, m_wd, m_cnt, 1'b0);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h02, 8'h00);
      check_regs("saturate", m_wa, m_wd, 8'hFF, 1'b0);
      send_frame(8'h03, 8'h04, 8'h07);
      check_regs("sat_then_good", 8'h03, 8'h04, 8'hFF, 1'b0);
   endtask

   task automatic test_mid_reset();
      send_byte(8'hA5); send_byte(8'h10);
      do_reset();
      send_byte(8'h22); send_byte(8'h32);
      check_regs("after_reset_tail", 8'h00, 8'h00, 8'h00, 1'b0);
      send_frame(8'h44, 8'h11, 8'h55);
      check_regs("after_reset_good", 8'h44, 8'h11, 8'h00, 1'b0);
   endtask

`ifdef CMD_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      send_byte(8'hA5); send_byte(8'h10);
      m_st = 0; push_ev(1'b1);
      n = 0;
      while (q.size() != 0 && n < 3 * int'(TO)) begin @(negedge clk); #1; n++; end
      checks++;
      if (q.size() != 0 || n != int'(TO)) begin
         errors++;
         $display("FAIL timeout: error seen after %0d cycles (pending %0d), want %0d", n, q.size(), TO);
         q.delete();
      end
      check_regs("timeout_idle", 8'h44, 8'h11, m_cnt, 1'b0);
      send_byte(8'hA5); send_byte(8'h10);
      repeat (int'(TO) - 2) @(negedge clk);
      send_byte(8'h22);
      check_regs("expiry_byte_wins", 8'h44, 8'h11, m_cnt, 1'b1);
      send_byte(8'h32);
      check_regs("expiry_frame_done", 8'h10, 8'h22, m_cnt, 1'b0);
   endtask
`else
   task automatic test_no_timeout();
      send_byte(8'hA5); send_byte(8'h10);
      repeat (3 * int'(TO)) @(negedge clk);
      check_regs("partial_waits", 8'h44, 8'h11, 8'h00, 1'b1);
      send_byte(8'h22); send_byte(8'h32);
      check_regs("partial_done", 8'h10, 8'h22, 8'h00, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_good();
      test_bad();
      test_junk_carry();
      test_sync_as_addr();
      test_random();
      test_saturation();
      test_mid_reset();
`ifdef CMD_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      repeat (5) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected events never produced", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
